// File: rtl/id_stage_hz_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats, instruction
// field layout and operand-usage helpers for the decode stage.
package id_stage_hz_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_BAD
  } imm_type_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv_instr_t;

  // IMM_BAD marks opcodes outside the RV32I base set.
  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      OPC_OP, OPC_SYSTEM, OPC_FENCE:  return IMM_NONE;
      default:                        return IMM_BAD;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/id_stage_hz_if.sv
// IF/ID, WB and ID/EX signal bundle of the decode stage. master is the
// surrounding pipeline, slave is the decode stage itself.
interface id_stage_hz_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 16
);

  logic            if_valid;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] pc_4_in;
  logic            flush;
  logic            ex_stall;
  logic            reg_write_en;
  logic [AW-1:0]   reg_write_addr;
  logic [XLEN-1:0] reg_write_data;

  logic             stall_if;
  logic             id_ex_valid;
  logic [XLEN-1:0]  id_ex_pc;
  logic [XLEN-1:0]  id_ex_pc_4;
  logic [XLEN-1:0]  id_ex_rs1_data;
  logic [XLEN-1:0]  id_ex_rs2_data;
  logic [AW-1:0]    id_ex_rs1;
  logic [AW-1:0]    id_ex_rs2;
  logic [AW-1:0]    id_ex_rd;
  logic [2:0]       id_ex_funct3;
  logic [6:0]       id_ex_funct7;
  logic [6:0]       id_ex_opcode;
  logic [XLEN-1:0]  id_ex_imm;
  logic             id_ex_illegal;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output if_valid, instr_in, pc_in, pc_4_in, flush, ex_stall,
           reg_write_en, reg_write_addr, reg_write_data,
    input  stall_if, id_ex_valid, id_ex_pc, id_ex_pc_4, id_ex_rs1_data,
           id_ex_rs2_data, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct3,
           id_ex_funct7, id_ex_opcode, id_ex_imm, id_ex_illegal, stall_count
  );

  modport slave (
    input  if_valid, instr_in, pc_in, pc_4_in, flush, ex_stall,
           reg_write_en, reg_write_addr, reg_write_data,
    output stall_if, id_ex_valid, id_ex_pc, id_ex_pc_4, id_ex_rs1_data,
           id_ex_rs2_data, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct3,
           id_ex_funct7, id_ex_opcode, id_ex_imm, id_ex_illegal, stall_count
  );

endinterface

// File: rtl/id_stage_hz_hazard_unit.sv
// Load-use detection against the instruction currently held in ID/EX, and
// the resulting front-end hold request.
module id_hazard_unit
  import id_stage_hz_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic          id_ex_valid_i,
  input  logic [6:0]    id_ex_opcode_i,
  input  logic [AW-1:0] id_ex_rd_i,
  input  logic          if_valid_i,
  input  logic [6:0]    opcode_i,
  input  logic [AW-1:0] rs1_i,
  input  logic [AW-1:0] rs2_i,
  input  logic          ex_stall_i,
  input  logic          flush_i,
  output logic          load_use_c_o,
  output logic          stall_if_c_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = uses_rs1(opcode_i) && (rs1_i == id_ex_rd_i);
  assign rs2_hit = uses_rs2(opcode_i) && (rs2_i == id_ex_rd_i);

  assign load_use_c_o = id_ex_valid_i && (id_ex_opcode_i == OPC_LOAD) &&
                        (id_ex_rd_i != '0) && if_valid_i && (rs1_hit || rs2_hit);

  // A redirect discards whatever IF/ID holds, so it never needs holding.
  assign stall_if_c_o = (ex_stall_i || load_use_c_o) && !flush_i;

endmodule

// File: rtl/id_stage_hz_reg_file.sv
// Integer register file: two asynchronous read ports, one write port,
// x0 hardwired to zero, cleared by synchronous reset.
module reg_file #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_c_o,
  output logic [XLEN-1:0] rdata2_c_o
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_c_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_c_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/id_stage_hz.sv
// RV32I decode stage: field extraction, immediate generation, register read
// with optional WB bypass, load-use bubbles and the ID/EX pipeline register.
module id_stage_hz
  import id_stage_hz_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned NREG      = 32,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_hz_if.slave     bus
);

  localparam int unsigned AW = $clog2(NREG);

  rv_instr_t       instr;
  logic [AW-1:0]   rs1_a;
  logic [AW-1:0]   rs2_a;
  logic [AW-1:0]   rd_a;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic            illegal;
  logic            load_use;
  logic            wb_fwd;

  logic             valid_q,    valid_d;
  logic [XLEN-1:0]  pc_q,       pc_d;
  logic [XLEN-1:0]  pc_4_q,     pc_4_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [AW-1:0]    rs1_q,      rs1_d;
  logic [AW-1:0]    rs2_q,      rs2_d;
  logic [AW-1:0]    rd_q,       rd_d;
  logic [2:0]       funct3_q,   funct3_d;
  logic [6:0]       funct7_q,   funct7_d;
  logic [6:0]       opcode_q,   opcode_d;
  logic [XLEN-1:0]  imm_q,      imm_d;
  logic             illegal_q,  illegal_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  assign instr = bus.instr_in;
  assign rs1_a = AW'(instr.rs1);
  assign rs2_a = AW'(instr.rs2);
  assign rd_a  = AW'(instr.rd);

  reg_file #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .we_i       (bus.reg_write_en),
    .waddr_i    (bus.reg_write_addr),
    .wdata_i    (bus.reg_write_data),
    .raddr1_i   (rs1_a),
    .raddr2_i   (rs2_a),
    .rdata1_c_o (rf_rd1),
    .rdata2_c_o (rf_rd2)
  );

  id_hazard_unit #(
    .AW (AW)
  ) u_hazard (
    .id_ex_valid_i  (valid_q),
    .id_ex_opcode_i (opcode_q),
    .id_ex_rd_i     (rd_q),
    .if_valid_i     (bus.if_valid),
    .opcode_i       (instr.opcode),
    .rs1_i          (rs1_a),
    .rs2_i          (rs2_a),
    .ex_stall_i     (bus.ex_stall),
    .flush_i        (bus.flush),
    .load_use_c_o   (load_use),
    .stall_if_c_o   (bus.stall_if)
  );

  // Write-through: a WB write in the same cycle wins over the array contents.
  assign wb_fwd  = (WB_BYPASS != 0) && bus.reg_write_en && (bus.reg_write_addr != '0);
  assign rs1_val = (rs1_a == '0) ? '0 :
                   (wb_fwd && (bus.reg_write_addr == rs1_a)) ? bus.reg_write_data : rf_rd1;
  assign rs2_val = (rs2_a == '0) ? '0 :
                   (wb_fwd && (bus.reg_write_addr == rs2_a)) ? bus.reg_write_data : rf_rd2;

  // Immediate mux, sign-extended from the instruction's top bit.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_type_of(instr.opcode))
      IMM_I:   imm = XLEN'($signed(bus.instr_in[31:20]));
      IMM_S:   imm = XLEN'($signed({instr.funct7, instr.rd}));
      IMM_B:   imm = XLEN'($signed({bus.instr_in[31], bus.instr_in[7],
                                    bus.instr_in[30:25], bus.instr_in[11:8], 1'b0}));
      IMM_U:   imm = XLEN'($signed({bus.instr_in[31:12], 12'b0}));
      IMM_J:   imm = XLEN'($signed({bus.instr_in[31], bus.instr_in[19:12],
                                    bus.instr_in[20], bus.instr_in[30:21], 1'b0}));
      IMM_BAD: illegal = bus.if_valid;
      default: imm = '0;
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    pc_4_d     = pc_4_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    funct7_d   = funct7_q;
    opcode_d   = opcode_q;
    imm_d      = imm_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (!bus.ex_stall) begin
      if (load_use) begin
        valid_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        valid_d    = bus.if_valid;
        pc_d       = bus.pc_in;
        pc_4_d     = bus.pc_4_in;
        rs1_data_d = rs1_val;
        rs2_data_d = rs2_val;
        rs1_d      = rs1_a;
        rs2_d      = rs2_a;
        rd_d       = rd_a;
        funct3_d   = instr.funct3;
        funct7_d   = instr.funct7;
        opcode_d   = instr.opcode;
        imm_d      = imm;
        illegal_d  = illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_4_q     <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7_q   <= '0;
      opcode_q   <= '0;
      imm_q      <= '0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pc_4_q     <= pc_4_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7_q   <= funct7_d;
      opcode_q   <= opcode_d;
      imm_q      <= imm_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.id_ex_valid    = valid_q;
  assign bus.id_ex_pc       = pc_q;
  assign bus.id_ex_pc_4     = pc_4_q;
  assign bus.id_ex_rs1_data = rs1_data_q;
  assign bus.id_ex_rs2_data = rs2_data_q;
  assign bus.id_ex_rs1      = rs1_q;
  assign bus.id_ex_rs2      = rs2_q;
  assign bus.id_ex_rd       = rd_q;
  assign bus.id_ex_funct3   = funct3_q;
  assign bus.id_ex_funct7   = funct7_q;
  assign bus.id_ex_opcode   = opcode_q;
  assign bus.id_ex_imm      = imm_q;
  assign bus.id_ex_illegal  = illegal_q;
  assign bus.stall_count    = cnt_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: three configurations (bypass on, bypass off, 2-bit
// counter) share one stimulus stream and are checked against a decode model.
module tb_id_stage_hz;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [31:0] imm;
    logic        ill;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv = 1'b0, fl = 1'b0, es = 1'b0, we = 1'b0;
  logic [31:0] ins = '0, pc = '0, wd = '0;
  logic [4:0]  wa = '0;

  rec_t        obs_rec [3];
  logic [15:0] obs_cnt [3];
  logic        obs_sif [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned BP = (g == 1) ? 0 : 1;
    localparam int unsigned CW = (g == 2) ? 2 : 16;
    id_stage_hz_if #(.XLEN(32), .AW(5), .CNT_W(CW)) bus ();
    assign bus.if_valid       = iv;
    assign bus.instr_in       = ins;
    assign bus.pc_in          = pc;
    assign bus.pc_4_in        = pc + 32'd4;
    assign bus.flush          = fl;
    assign bus.ex_stall       = es;
    assign bus.reg_write_en   = we;
    assign bus.reg_write_addr = wa;
    assign bus.reg_write_data = wd;
    id_stage_hz #(.XLEN(32), .NREG(32), .WB_BYPASS(BP), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign obs_rec[g] = {bus.id_ex_valid, bus.id_ex_pc, bus.id_ex_pc_4, bus.id_ex_rs1_data,
                         bus.id_ex_rs2_data, bus.id_ex_rs1, bus.id_ex_rs2, bus.id_ex_rd,
                         bus.id_ex_funct3, bus.id_ex_funct7, bus.id_ex_opcode,
                         bus.id_ex_imm, bus.id_ex_illegal};
    assign obs_cnt[g] = 16'(bus.stall_count);
    assign obs_sif[g] = bus.stall_if;
  end

  int          n_chk = 0;
  int          n_fail = 0;
  rec_t        m_rec [3];
  logic        m_known [3];
  int          m_cnt [3];
  logic [31:0] m_rf [3][32];
  logic        m_init = 1'b0;
  logic        exp_sif = 1'b0;
  logic        sif_seen = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction format class; "N" has no immediate, "X" is not RV32I.
  function automatic string fmt(input logic [6:0] op);
    case (op)
      7'b0110011:                         return "R";
      7'b0010011, 7'b0000011, 7'b1100111: return "I";
      7'b0100011:                         return "S";
      7'b1100011:                         return "B";
      7'b0110111, 7'b0010111:             return "U";
      7'b1101111:                         return "J";
      7'b1110011, 7'b0001111:             return "N";
      default:                            return "X";
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (fmt(i[6:0]))
      "I": v = $signed(i) >>> 20;
      "S": v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
      "B": v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      "U": v = int'(i & 32'hFFFF_F000);
      "J": v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
               int'(i[30:21]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] rd_op(input int k, input logic [4:0] addr, input logic w,
                                        input logic [4:0] a, input logic [31:0] d);
    if (addr == 5'd0) return 32'd0;
    if (k != 1 && w && a != 5'd0 && a == addr) return d;
    return m_rf[k][addr];
  endfunction

  task automatic step(input logic r, input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic f, input logic s, input logic w, input logic [4:0] a,
                      input logic [31:0] d);
    logic  lu, r1u, r2u;
    rec_t  nr;
    string t;
    @(negedge clk);
    rst = r; iv = v; ins = i; pc = p; fl = f; es = s; we = w; wa = a; wd = d;
    #1;
    t   = fmt(i[6:0]);
    r1u = (t == "R") || (t == "I") || (t == "S") || (t == "B");
    r2u = (t == "R") || (t == "S") || (t == "B");
    lu  = m_init && m_rec[0].valid && m_rec[0].opc == 7'b0000011 && m_rec[0].rd != 5'd0 && v &&
          ((r1u && i[19:15] == m_rec[0].rd) || (r2u && i[24:20] == m_rec[0].rd));
    exp_sif  = (s || lu) && !f;
    sif_seen = obs_sif[0];
    if (m_init) begin
      for (int k = 0; k < 3; k++) check($sformatf("stall_if%0d", k), 256'(obs_sif[k]), 256'(exp_sif));
    end
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_rec[k] = '0; m_known[k] = 1'b1; m_cnt[k] = 0;
        for (int j = 0; j < 32; j++) m_rf[k][j] = '0;
      end else begin
        if (f) begin
          m_rec[k].valid = 1'b0; m_known[k] = 1'b0;
        end else if (!s) begin
          if (lu) begin
            m_rec[k].valid = 1'b0; m_known[k] = 1'b0;
            if (m_cnt[k] < ((k == 2) ? 3 : 65535)) m_cnt[k]++;
          end else begin
            nr.valid = v;        nr.pc = p;           nr.pc4 = p + 32'd4;
            nr.rs1d = rd_op(k, i[19:15], w, a, d);
            nr.rs2d = rd_op(k, i[24:20], w, a, d);
            nr.rs1 = i[19:15];   nr.rs2 = i[24:20];   nr.rd = i[11:7];
            nr.f3 = i[14:12];    nr.f7 = i[31:25];    nr.opc = i[6:0];
            nr.imm = ref_imm(i); nr.ill = (t == "X") && v;
            m_rec[k] = nr; m_known[k] = 1'b1;
          end
        end
        if (w && a != 5'd0) m_rf[k][a] = d;
      end
    end
    if (r) m_init = 1'b1;
    @(posedge clk);
    #1;
    if (m_init) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("valid%0d", k), 256'(obs_rec[k].valid), 256'(m_rec[k].valid));
        if (m_known[k]) check($sformatf("rec%0d", k), 256'(obs_rec[k]), 256'(m_rec[k]));
        check($sformatf("cnt%0d", k), 256'(obs_cnt[k]), 256'(m_cnt[k]));
      end
    end
  endtask

  task automatic issue(input logic [31:0] i);
    step(1'b0, 1'b1, i, 32'h0000_1000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0]  op;
    i = $urandom;
    case ($urandom_range(13))
      0, 1, 2: op = 7'b0000011;
      3:       op = 7'b0110011;
      4:       op = 7'b0010011;
      5:       op = 7'b0100011;
      6:       op = 7'b1100011;
      7:       op = 7'b1100111;
      8:       op = 7'b0110111;
      9:       op = 7'b0010111;
      10:      op = 7'b1101111;
      11:      op = 7'b1110011;
      12:      op = 7'b0001111;
      default: op = 7'h7F;
    endcase
    i[6:0]   = op;
    i[11:7]  = 5'($urandom_range(3));
    i[19:15] = 5'($urandom_range(3));
    i[24:20] = 5'($urandom_range(3));
    return i;
  endfunction

  initial begin
    rec_t        saved;
    int          saved_cnt;
    logic        cv;
    logic [31:0] ci, cp;

    do_reset();
    check("rst_rec", 256'(obs_rec[0]), 256'(0));
    check("rst_cnt", 256'(obs_cnt[0]), 256'(0));
    check("rst_sif", 256'(obs_sif[0]), 256'(0));

    issue(32'hFE00_0EE3);
    check("imm_b", 256'(obs_rec[0].imm), 256'(32'hFFFF_FFFC));
    issue(32'hFE00_0E63);
    check("imm_b2", 256'(obs_rec[0].imm), 256'(32'hFFFF_F7FC));
    issue(32'h8000_006F);
    check("imm_j", 256'(obs_rec[0].imm), 256'(32'hFFF0_0000));
    issue(32'h0000_007F);
    check("illegal", 256'(obs_rec[0].ill), 256'(1));
    check("illegal_imm", 256'(obs_rec[0].imm), 256'(0));

    issue(32'h0000_A283);
    issue(32'h0022_8333);
    check("lu_sif", 256'(sif_seen), 256'(1));
    check("lu_bubble", 256'(obs_rec[0].valid), 256'(0));
    issue(32'h0022_8333);
    check("lu_release", 256'(sif_seen), 256'(0));
    check("lu_issue", 256'({obs_rec[0].valid, obs_rec[0].rd}), 256'({1'b1, 5'd6}));
    check("lu_cnt", 256'(obs_cnt[0]), 256'(1));
    issue(32'h0000_A003);
    issue(32'h0020_0333);
    check("lu_x0_sif", 256'(sif_seen), 256'(0));
    check("lu_x0_valid", 256'(obs_rec[0].valid), 256'(1));

    step(1'b0, 1'b1, 32'h0003_8413, 32'h0000_2000, 1'b0, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    check("bypass", 256'(obs_rec[0].rs1d), 256'(32'hDEAD_BEEF));
    check("no_bypass", 256'(obs_rec[1].rs1d), 256'(0));
    issue(32'h0003_8413);
    check("no_bypass_late", 256'(obs_rec[1].rs1d), 256'(32'hDEAD_BEEF));
    step(1'b0, 1'b1, 32'h0000_0413, 32'h0000_2004, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234_5678);
    issue(32'h0000_0413);
    check("x0_read", 256'(obs_rec[0].rs1d), 256'(0));

    step(1'b0, 1'b1, 32'h0022_8333, 32'h0000_3000, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    check("flush_sif", 256'(sif_seen), 256'(0));
    check("flush_valid", 256'(obs_rec[0].valid), 256'(0));
    issue(32'h0003_8413);
    saved     = m_rec[0];
    saved_cnt = m_cnt[0];
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b1, 32'h0022_8333, 32'h0000_3004, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      check("hold_sif", 256'(sif_seen), 256'(1));
      check("hold_rec", 256'(obs_rec[0]), 256'(saved));
      check("hold_cnt", 256'(obs_cnt[0]), 256'(saved_cnt));
    end

    do_reset();
    for (int n = 0; n < 5; n++) begin
      issue(32'h0000_A283);
      issue(32'h0022_8333);
      issue(32'h0022_8333);
    end
    check("sat_cnt2", 256'(obs_cnt[2]), 256'(3));
    check("sat_cnt16", 256'(obs_cnt[0]), 256'(5));

    cv = 1'b0; ci = '0; cp = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!exp_sif) begin
        cv = ($urandom_range(9) != 0);
        ci = rand_instr();
        cp = $urandom & 32'hFFFF_FFFC;
      end
      step(($urandom_range(199) == 0), cv, ci, cp, ($urandom_range(9) == 0),
           ($urandom_range(5) == 0), 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
